// File: rtl/l0_maxpool_if.sv
// Bundles the window-read port and the pooled-output stream of l0_maxpool.
// master = pooling stage, slave = RAM/consumer side.
interface l0_maxpool_if #(
  parameter int unsigned DW = 18,
  parameter int unsigned AW = 10,
  parameter int unsigned OW = 8
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd;
  logic [AW-1:0]        addr_rd;
  logic [3:0][DW-1:0]   din;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [OW-1:0]        out_idx;
  logic                 out_last;

  modport master (
    input  start, din, out_ready,
    output busy, done, rd, addr_rd, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output start, din, out_ready,
    input  busy, done, rd, addr_rd, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/l0_maxpool.sv
// 2x2 / stride-2 max-pool over the layer-0 feature map, 1-deep output register.
// Optional macro POOL_RELU_EN clamps negative maxima to zero.
module l0_maxpool #(
  parameter int unsigned IN_DIM = 26,
  parameter int unsigned DW     = 18,
  parameter int unsigned AW     = 10,
  parameter int unsigned OW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  l0_maxpool_if.master  bus
);
  localparam int unsigned OUT_DIM = IN_DIM / 2;
  localparam int unsigned NWIN    = OUT_DIM * OUT_DIM;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [OW-1:0] win_q, win_d;   // index of the next window to issue
  logic [OW-1:0] col_q, col_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [OW-1:0] idx_q, idx_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic          rd;
  logic          accept;
  logic          last_win;
  logic signed [DW-1:0] m01, m23, mx, pooled;

  always_comb begin
    m01 = ($signed(bus.din[0]) > $signed(bus.din[1])) ? $signed(bus.din[0])
                                                      : $signed(bus.din[1]);
    m23 = ($signed(bus.din[2]) > $signed(bus.din[3])) ? $signed(bus.din[2])
                                                      : $signed(bus.din[3]);
    mx  = (m01 > m23) ? m01 : m23;
`ifdef POOL_RELU_EN
    pooled = mx[DW-1] ? '0 : mx;
`else
    pooled = mx;
`endif
  end

  assign accept   = valid_q && bus.out_ready;
  assign last_win = (win_q == OW'(NWIN - 1));
  assign rd       = (state_q == StRun) && (!valid_q || bus.out_ready);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    win_d   = win_q;
    col_d   = col_q;
    valid_d = valid_q && !bus.out_ready;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = accept ? 1'b0 : last_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          addr_d  = AW'(IN_DIM + 1);
          win_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        if (rd) begin
          valid_d = 1'b1;
          data_d  = pooled;
          idx_d   = win_q;
          last_d  = last_win;
          if (last_win) begin
            state_d = StDrain;
          end else begin
            win_d = win_q + OW'(1);
            // Row end skips the odd row that the window already covered.
            if (col_q == OW'(OUT_DIM - 1)) begin
              col_d  = '0;
              addr_d = addr_q + AW'(IN_DIM + 2);
            end else begin
              col_d  = col_q + OW'(1);
              addr_d = addr_q + AW'(2);
            end
          end
        end
      end
      StDrain: begin
        if (accept && last_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      win_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.rd        = rd;
  assign bus.addr_rd   = addr_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
endmodule
